// File: rtl/writeback_trace_buffer.sv
// Retirement trace buffer: stamps qualifying write-back register writes with a sequence number
// and queues them in a FWFT FIFO. Optional shadow register file under `TRACE_SHADOW_RF_EN.
module writeback_trace_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_we,
    input  logic [4:0]               wb_rd,
    input  logic [31:0]              wb_data,
    input  logic                     clear,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [4:0]               trace_rd,
    output logic [31:0]              trace_data,
    output logic [CNT_W-1:0]         trace_seq,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
`ifdef TRACE_SHADOW_RF_EN
    input  logic [4:0]               shadow_addr,
    output logic [31:0]              shadow_data,
`endif
    output logic [CNT_W-1:0]         drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [4:0]       mem_rd_q   [DEPTH];
    logic [31:0]      mem_data_q [DEPTH];
    logic [CNT_W-1:0] mem_seq_q  [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] seq_q, seq_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             ovf_q, ovf_d;

    logic qual, pop, push, drop;

    assign qual = wb_we && (wb_rd != '0);
    assign full = (level_q == LW'(DEPTH));
    assign pop  = trace_valid && trace_ready;
    assign push = qual && (!full || pop);
    assign drop = qual && full && !pop;

    assign trace_valid = (level_q != '0);
    assign trace_rd    = mem_rd_q[rd_ptr_q];
    assign trace_data  = mem_data_q[rd_ptr_q];
    assign trace_seq   = mem_seq_q[rd_ptr_q];
    assign level       = level_q;
    assign overflow    = ovf_q;
    assign drop_count  = drop_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        seq_d    = seq_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            seq_d    = '0;
            drop_d   = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      level_d = level_q + LW'(1);
            else if (pop && !push) level_d = level_q - LW'(1);
            // Every qualifying write consumes a sequence number, stored or dropped.
            if (qual) seq_d = seq_q + CNT_W'(1);
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_rd_q[i]   <= '0;
                mem_data_q[i] <= '0;
                mem_seq_q[i]  <= '0;
            end
        end else if (push && !clear) begin
            mem_rd_q[wr_ptr_q]   <= wb_rd;
            mem_data_q[wr_ptr_q] <= wb_data;
            mem_seq_q[wr_ptr_q]  <= seq_q;
        end
    end

`ifdef TRACE_SHADOW_RF_EN
    logic [31:0] shadow_q [32];

    // Tracks architectural state, so it updates on dropped writes and ignores clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 32; i++) shadow_q[i] <= '0;
        end else if (qual) begin
            shadow_q[wb_rd] <= wb_data;
        end
    end

    assign shadow_data = (shadow_addr == '0) ? '0 : shadow_q[shadow_addr];
`endif

endmodule

// File: tb/tb_writeback_trace_buffer.sv
// Directed self-checking bench for writeback_trace_buffer (DEPTH=8, CNT_W=16).
module tb_writeback_trace_buffer;

    logic        clk;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        clear;
    logic        trace_valid;
    logic        trace_ready;
    logic [4:0]  trace_rd;
    logic [31:0] trace_data;
    logic [15:0] trace_seq;
    logic [3:0]  level;
    logic        full;
    logic        overflow;
    logic [15:0] drop_count;
`ifdef TRACE_SHADOW_RF_EN
    logic [4:0]  shadow_addr;
    logic [31:0] shadow_data;
`endif

    int n_cmp = 0;
    int n_err = 0;

    writeback_trace_buffer #(.DEPTH(8), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .clear       (clear),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_rd    (trace_rd),
        .trace_data  (trace_data),
        .trace_seq   (trace_seq),
        .level       (level),
        .full        (full),
        .overflow    (overflow),
`ifdef TRACE_SHADOW_RF_EN
        .shadow_addr (shadow_addr),
        .shadow_data (shadow_data),
`endif
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; wb_we = 1'b0; trace_ready = 1'b0;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0; clear = 1'b0; trace_ready = 1'b0;
`ifdef TRACE_SHADOW_RF_EN
        shadow_addr = '0;
`endif
        #12;
        n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", trace_valid); end
        n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %0b want 0", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL reset_drop got %0d want 0", drop_count); end
        n_cmp++; if ({trace_rd, trace_data, trace_seq} !== 53'd0) begin n_err++; $display("FAIL reset_head got %h/%h/%h want 0", trace_rd, trace_data, trace_seq); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        trace_ready = 1'b1;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h11;
        step();
        n_cmp++; if ({trace_valid, trace_rd, trace_data, trace_seq} !== {1'b1, 5'd5, 32'h11, 16'd0})
            begin n_err++; $display("FAIL basic_first got v%0b rd%0d d%h s%0d want v1 rd5 d11 s0", trace_valid, trace_rd, trace_data, trace_seq); end
        wb_rd = 5'd0; wb_data = 32'h22;
        step();
        n_cmp++; if ({trace_valid, level} !== {1'b0, 4'd0}) begin n_err++; $display("FAIL basic_x0_skip got v%0b l%0d want v0 l0", trace_valid, level); end
        wb_rd = 5'd6; wb_data = 32'h33;
        step();
        n_cmp++; if ({trace_valid, trace_rd, trace_data, trace_seq} !== {1'b1, 5'd6, 32'h33, 16'd1})
            begin n_err++; $display("FAIL basic_second got v%0b rd%0d d%h s%0d want v1 rd6 d33 s1", trace_valid, trace_rd, trace_data, trace_seq); end
        wb_we = 1'b0;
        step();
        n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL basic_drained got %0d want 0", level); end
        trace_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_clear();
        for (int i = 0; i < 10; i++) begin
            wb_we = 1'b1; wb_rd = 5'(i + 1); wb_data = 32'h100 + 32'(i);
            step();
            if (i == 7) begin
                n_cmp++; if ({full, level} !== {1'b1, 4'd8}) begin n_err++; $display("FAIL ovf_full got f%0b l%0d want f1 l8", full, level); end
            end
        end
        wb_we = 1'b0;
        n_cmp++; if ({overflow, drop_count, level} !== {1'b1, 16'd2, 4'd8})
            begin n_err++; $display("FAIL ovf_drops got o%0b d%0d l%0d want o1 d2 l8", overflow, drop_count, level); end
        trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if ({trace_valid, trace_seq, trace_rd, trace_data} !== {1'b1, 16'(i), 5'(i + 1), 32'h100 + 32'(i)})
                begin n_err++; $display("FAIL ovf_drain%0d got v%0b s%0d rd%0d d%h want seq %0d", i, trace_valid, trace_seq, trace_rd, trace_data, i); end
            step();
        end
        trace_ready = 1'b0;
        n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL ovf_empty got %0d want 0", level); end
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hAB;
        step();
        wb_we = 1'b0;
        n_cmp++; if ({trace_valid, trace_seq} !== {1'b1, 16'd10}) begin n_err++; $display("FAIL ovf_next_seq got v%0b s%0d want v1 s10", trace_valid, trace_seq); end
        trace_ready = 1'b1;
        step();
        trace_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_clear();
        for (int i = 0; i < 8; i++) begin
            wb_we = 1'b1; wb_rd = 5'(i + 1); wb_data = 32'h200 + 32'(i);
            step();
        end
        wb_rd = 5'd9; wb_data = 32'h999; trace_ready = 1'b1;
        step();
        wb_we = 1'b0;
        n_cmp++; if ({level, full, drop_count, overflow} !== {4'd8, 1'b1, 16'd0, 1'b0})
            begin n_err++; $display("FAIL b2b_level got l%0d f%0b d%0d o%0b want l8 f1 d0 o0", level, full, drop_count, overflow); end
        for (int i = 1; i < 9; i++) begin
            n_cmp++; if ({trace_valid, trace_seq} !== {1'b1, 16'(i)})
                begin n_err++; $display("FAIL b2b_drain%0d got v%0b s%0d want v1 s%0d", i, trace_valid, trace_seq, i); end
            if (i == 8) begin
                n_cmp++; if ({trace_rd, trace_data} !== {5'd9, 32'h999}) begin n_err++; $display("FAIL b2b_last got rd%0d d%h want rd9 d999", trace_rd, trace_data); end
            end
            step();
        end
        trace_ready = 1'b0;
    endtask

    task automatic test_clear();
        do_clear();
        for (int i = 0; i < 9; i++) begin
            wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h300 + 32'(i);
            step();
        end
        wb_we = 1'b0; trace_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        trace_ready = 1'b0;
        n_cmp++; if ({level, overflow, drop_count} !== {4'd3, 1'b1, 16'd1})
            begin n_err++; $display("FAIL clr_pre got l%0d o%0b d%0d want l3 o1 d1", level, overflow, drop_count); end
        clear = 1'b1; wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h44; trace_ready = 1'b1;
        step();
        clear = 1'b0; trace_ready = 1'b0;
        n_cmp++; if ({level, trace_valid, overflow, drop_count, full} !== {4'd0, 1'b0, 1'b0, 16'd0, 1'b0})
            begin n_err++; $display("FAIL clr_post got l%0d v%0b o%0b d%0d f%0b want all 0", level, trace_valid, overflow, drop_count, full); end
        wb_rd = 5'd2; wb_data = 32'h55;
        step();
        wb_we = 1'b0;
        n_cmp++; if ({trace_valid, trace_rd, trace_data, trace_seq} !== {1'b1, 5'd2, 32'h55, 16'd0})
            begin n_err++; $display("FAIL clr_seq got v%0b rd%0d d%h s%0d want v1 rd2 d55 s0", trace_valid, trace_rd, trace_data, trace_seq); end
    endtask

    task automatic test_async_reset();
        do_clear();
        for (int i = 0; i < 4; i++) begin
            wb_we = 1'b1; wb_rd = 5'd8; wb_data = 32'h400 + 32'(i);
            step();
        end
        wb_we = 1'b0;
        n_cmp++; if (level !== 4'd4) begin n_err++; $display("FAIL arst_pre got %0d want 4", level); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({trace_valid, level, full, overflow, drop_count} !== {1'b0, 4'd0, 1'b0, 1'b0, 16'd0})
            begin n_err++; $display("FAIL arst_state got v%0b l%0d f%0b o%0b d%0d want 0", trace_valid, level, full, overflow, drop_count); end
        n_cmp++; if ({trace_rd, trace_data, trace_seq} !== 53'd0)
            begin n_err++; $display("FAIL arst_head got %h/%h/%h want 0", trace_rd, trace_data, trace_seq); end
        #2 reset = 1'b1;
        step();
        n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL arst_after got %0d want 0", level); end
    endtask

`ifdef TRACE_SHADOW_RF_EN
    task automatic test_shadow();
        do_clear();
        for (int i = 0; i < 8; i++) begin
            wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'(i);
            step();
        end
        wb_rd = 5'd7; wb_data = 32'hDEADBEEF; shadow_addr = 5'd7;
        step();
        wb_we = 1'b0;
        n_cmp++; if (drop_count !== 16'd1) begin n_err++; $display("FAIL shd_drop got %0d want 1", drop_count); end
        n_cmp++; if (shadow_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL shd_x7 got %h want deadbeef", shadow_data); end
        shadow_addr = 5'd0;
        #1;
        n_cmp++; if (shadow_data !== 32'd0) begin n_err++; $display("FAIL shd_x0 got %h want 0", shadow_data); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_clear();
        test_async_reset();
`ifdef TRACE_SHADOW_RF_EN
        test_shadow();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
